// File: rtl/ex_divider_pkg.sv
// ex_divider_pkg: shared execute-stage definitions for the divider.
package ex_divider_pkg;
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_e;

    function automatic logic is_signed(input div_op_e op);
        return op == OP_DIV || op == OP_REM;
    endfunction

    function automatic logic is_rem(input div_op_e op);
        return op == OP_REM || op == OP_REMU;
    endfunction
endpackage

// File: rtl/ex_divider_div_step.sv
// div_step: one radix-2 restoring iteration, producing one quotient bit MSB first.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          fits;

    // Partial remainder is widened by one bit so the trial subtract cannot wrap.
    assign shifted  = {rem, quo[XLEN-1]};
    assign diff     = shifted - {1'b0, divisor};
    assign fits     = ~diff[XLEN];
    assign rem_next = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_next = {quo[XLEN-2:0], fits};
endmodule

// File: rtl/ex_divider.sv
// ex_divider: multi-cycle signed/unsigned divide and remainder for the execute stage.
// Divide-by-zero and signed overflow bypass the iteration and complete in one cycle.
module ex_divider
    import ex_divider_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            div_start,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] s1,
    input  logic [XLEN-1:0] s2,
    input  logic            flush,
    output logic            div_busy,
    output logic            div_done,
    output logic [XLEN-1:0] div_result
);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state;
    div_op_e         op;
    div_op_e         op_in;
    logic [5:0]      cnt;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvsr;
    logic [XLEN-1:0] quo_nxt;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            neg_q;
    logic            neg_r;
    logic            sgn_in;
    logic            div_zero;
    logic            ovf;

    assign op_in    = div_op_e'(div_op);
    assign sgn_in   = is_signed(op_in);
    assign abs_a    = (sgn_in && s1[XLEN-1]) ? -s1 : s1;
    assign abs_b    = (sgn_in && s2[XLEN-1]) ? -s2 : s2;
    assign div_zero = s2 == '0;
    assign ovf      = sgn_in && s1 == MIN_INT && &s2;

    // Sign fix-up applies to the final iteration's output so DONE carries the finished value.
    assign q_fix = neg_q ? -quo_nxt : quo_nxt;
    assign r_fix = neg_r ? -rem_nxt : rem_nxt;

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvsr),
        .rem_next (rem_nxt),
        .quo_next (quo_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op         <= OP_DIV;
            cnt        <= '0;
            quo        <= '0;
            rem        <= '0;
            dvsr       <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_busy   <= 1'b0;
            div_done   <= 1'b0;
            div_result <= '0;
        end else begin
            div_done <= 1'b0;
            if (flush) begin
                state    <= IDLE;
                div_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (div_start) begin
                        op       <= op_in;
                        div_busy <= 1'b1;
                        if (div_zero || ovf) begin
                            state      <= DONE;
                            div_done   <= 1'b1;
                            div_result <= div_zero ? (is_rem(op_in) ? s1 : '1)
                                                   : (is_rem(op_in) ? '0 : MIN_INT);
                        end else begin
                            state <= CALC;
                            cnt   <= '0;
                            quo   <= abs_a;
                            rem   <= '0;
                            dvsr  <= abs_b;
                            neg_q <= sgn_in && (s1[XLEN-1] ^ s2[XLEN-1]);
                            neg_r <= sgn_in && s1[XLEN-1];
                        end
                    end
                    CALC: begin
                        quo <= quo_nxt;
                        rem <= rem_nxt;
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'(ITER - 1)) begin
                            state      <= DONE;
                            div_done   <= 1'b1;
                            div_result <= is_rem(op) ? r_fix : q_fix;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        div_busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ex_divider.sv
// tb_ex_divider: directed vectors with a scoreboard queue and an independent done monitor.
module tb_ex_divider;
    import ex_divider_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] result;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        div_start = 1'b0;
    logic [1:0]  div_op = 2'b00;
    logic [31:0] s1 = '0;
    logic [31:0] s2 = '0;
    logic        flush = 1'b0;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_result;

    exp_t sb[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    ex_divider #(.XLEN(32), .ITER(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_start  (div_start),
        .div_op     (div_op),
        .s1         (s1),
        .s2         (s2),
        .flush      (flush),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .div_result (div_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (div_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, div_result, e.result);
                check({e.name, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    task automatic launch(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input int lat);
        exp_t e;
        div_op    = op;
        s1        = a;
        s2        = b;
        div_start = 1'b1;
        e.name    = name;
        e.result  = res;
        e.cyc     = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            check({name, "_timeout"}, 32'd1, 32'd0);
            sb.delete();
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input int lat);
        @(negedge clk);
        launch(name, op, a, b, res, lat);
        @(negedge clk);
        div_start = 1'b0;
        check({name, "_busy"}, 32'(div_busy), 32'd1);
        wait_empty(name);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(div_busy), 32'd0);
        check("reset_done", 32'(div_done), 32'd0);
        check("reset_result", div_result, 32'd0);
        rst_n = 1'b1;

        run_op("divu_100_7",   OP_DIVU, 32'd100,        32'd7,          32'd14,         33);
        run_op("remu_100_7",   OP_REMU, 32'd100,        32'd7,          32'd2,          33);
        run_op("div_m7_2",     OP_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33);
        run_op("rem_m7_2",     OP_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33);
        run_op("div_m7_m2",    OP_DIV,  32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          33);
        run_op("div_7_m2",     OP_DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   33);
        run_op("rem_7_m2",     OP_REM,  32'd7,          32'hFFFFFFFE,   32'd1,          33);
        run_op("div_min_2",    OP_DIV,  32'h80000000,   32'd2,          32'hC0000000,   33);
        run_op("divu_max_1",   OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33);
        run_op("divu_min_m1",  OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          33);
        run_op("remu_min_m1",  OP_REMU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   33);
        run_op("divu_by0",     OP_DIVU, 32'h12345678,   32'd0,          32'hFFFFFFFF,   1);
        run_op("remu_by0",     OP_REMU, 32'h12345678,   32'd0,          32'h12345678,   1);
        run_op("div_by0",      OP_DIV,  32'h12345678,   32'd0,          32'hFFFFFFFF,   1);
        run_op("rem_by0",      OP_REM,  32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9,   1);
        run_op("div_ovf",      OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1);
        run_op("rem_ovf",      OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          1);

        // A second start mid-calculation must not disturb the accepted operands.
        @(negedge clk);
        launch("ignore_start", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        @(negedge clk);
        div_start = 1'b0;
        repeat (3) @(negedge clk);
        div_op = OP_REMU; s1 = 32'd1000; s2 = 32'd3; div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        wait_empty("ignore_start");

        // Flush at T+10 aborts; a fresh start at T+11 completes at T+44.
        @(negedge clk);
        t = cyc;
        div_op = OP_DIVU; s1 = 32'd500; s2 = 32'd3; div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        while (cyc != t + 10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(div_busy), 32'd0);
        check("flush_cycle", cyc, t + 11);
        launch("after_flush", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        @(negedge clk);
        div_start = 1'b0;
        wait_empty("after_flush");

        // Flush and start together: the start is dropped.
        @(negedge clk);
        div_op = OP_DIVU; s1 = 32'd5; s2 = 32'd1; div_start = 1'b1; flush = 1'b1;
        @(negedge clk);
        div_start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 32'(div_busy), 32'd0);
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-operation clears outputs at once.
        @(negedge clk);
        div_op = OP_DIVU; s1 = 32'd100; s2 = 32'd7; div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(div_busy), 32'd0);
        check("arst_done", 32'(div_done), 32'd0);
        check("arst_result", div_result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run_op("after_reset", OP_REMU, 32'd100, 32'd7, 32'd2, 33);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ex_divider.md
EX_DIVIDER -- requirements
Module: ex_divider

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have parameter ITER, default 32, number of iteration cycles; it SHALL equal XLEN.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port div_start  input  1  request to begin a division using s1/s2 from the ALU input mux.
REQ-006 SHALL have port div_op  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have port s1  input  32  dividend, as selected by the ALU input mux.
REQ-008 SHALL have port s2  input  32  divisor, as selected by the ALU input mux.
REQ-009 SHALL have port flush  input  1  pipeline flush; aborts any operation in progress.
REQ-010 SHALL have port div_busy  output  1  high while an accepted operation has not yet completed; the hazard unit uses it to stall ID/EX.
REQ-011 SHALL have port div_done  output  1  single-cycle pulse marking div_result as valid.
REQ-012 SHALL have port div_result  output  32  quotient or remainder, per the latched div_op.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-014 In IDLE, div_start=1 with flush=0 SHALL latch s1, s2 and div_op and set div_busy the following cycle.
REQ-015 div_start SHALL be ignored in CALC and DONE; operands are sampled only on acceptance.
REQ-016 Normal path: IDLE -> CALC for exactly 32 cycles (radix-2 restoring, one quotient bit per cycle, MSB first) -> DONE for 1 cycle -> IDLE.
REQ-017 Latency: for acceptance at cycle T, div_done=1 and the result is valid at cycle T+33; div_busy SHALL be high over T+1..T+33.
REQ-018 Signed ops (DIV, REM) SHALL divide absolute values, negate the quotient when the operand signs differ, and give the remainder the sign of the dividend.
REQ-019 Divide by zero SHALL take the fast path (IDLE -> DONE, result at T+1): quotient 0xFFFFFFFF for both DIV and DIVU; remainder equal to s1.
REQ-020 Signed overflow (s1=0x80000000, s2=0xFFFFFFFF, DIV/REM) SHALL take the fast path: quotient 0x80000000, remainder 0.
REQ-021 div_result SHALL hold its last value outside DONE; consumers SHALL qualify it with div_done.
REQ-022 flush=1 in any state SHALL force IDLE on the next edge, with no div_done for the aborted operation and div_busy low from the next cycle.
REQ-023 flush and div_start in the same cycle: flush SHALL win and the start SHALL be dropped.
REQ-024 flush during DONE SHALL NOT suppress the div_done already asserted that cycle.
REQ-025 Internal arithmetic SHALL use a 33-bit partial remainder so that the trial subtract never overflows.

Reset
REQ-026 While rst_n=0: state=IDLE, div_busy=0, div_done=0, div_result=0, and the iteration counter and operand registers cleared.
REQ-027 Reset assertion mid-operation SHALL abandon the operation immediately, asynchronously, with no div_done afterwards.
REQ-028 Reset release SHALL be synchronised externally; the block SHALL accept div_start from the first edge after release.

Structure
REQ-029 A shared execute-stage package SHALL hold the div_op encodings (DIV, DIVU, REM, REMU) and the FSM state typedef.
REQ-030 SHALL instantiate one sub-module, div_step: combinational single iteration (shift in dividend bit, trial subtract, next remainder and quotient bit).
REQ-031 The FSM, the 6-bit iteration counter, the sign fix-up and the special-case detection SHALL reside in ex_divider.

Verification
REQ-032 DIVU, s1=100, s2=7, start at T -> div_done at T+33 with result 14; same operands with REMU -> 2.
REQ-033 DIV, s1=0xFFFFFFF9 (-7), s2=2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIV -7/-2 -> 3.
REQ-034 DIVU, s1=0x12345678, s2=0 -> div_done at T+1 with result 0xFFFFFFFF; REMU -> 0x12345678.
REQ-035 DIV, s1=0x80000000, s2=0xFFFFFFFF -> result 0x80000000 at T+1; REM -> 0.
REQ-036 Start, then flush at T+10 -> div_busy low at T+11, no div_done; a new start at T+11 completes at T+44.
REQ-037 rst_n low at T+5 of an operation -> outputs zero immediately; no div_done after release; the next start behaves normally.
